uart_debug_controller: RTL
==========================

Name: uart_debug_controller

Overview:
Command sequencer between the UART block's FIFO-side interface and the MIPS pipeline. It pops command bytes from the UART RX FIFO and acts on them:
- loads program words into instruction memory;
- runs or single-steps the CPU;
- clears the CPU;
- streams PC and register-file contents back through the UART TX FIFO.

Sole owner of the UART read/write strobes and of the CPU enable.

Parameters:
DATA_W, 8, UART byte width
WORD_W, 32, instruction/register word width (multiple of DATA_W)
IMEM_ADDR_W, 8, instruction-memory word-address width
NUM_REGS, 32, registers dumped per report
REG_ADDR_W, 5, register-file address width

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous, active-low reset
i_rx_empty  in  1  UART RX FIFO empty
i_rx_data  in  DATA_W  RX FIFO head byte, valid while i_rx_empty=0
o_rd_uart  out  1  one-cycle pop of RX FIFO head
i_tx_full  in  1  UART TX FIFO full
o_wr_uart  out  1  one-cycle push of o_tx_data
o_tx_data  out  DATA_W  byte to transmit
o_imem_we  out  1  instruction-memory write strobe
o_imem_addr  out  IMEM_ADDR_W  word address
o_imem_wdata  out  WORD_W  word to write
o_cpu_enable  out  1  pipeline advances one cycle per high cycle
o_cpu_clear  out  1  one-cycle synchronous pipeline clear
i_halt  in  1  CPU reached halt instruction
i_pc  in  WORD_W  current PC
o_reg_addr  out  REG_ADDR_W  register-file read address (combinational read)
i_reg_data  in  WORD_W  register data for o_reg_addr, same cycle
o_busy  out  1  high in every state except IDLE

Behaviour:
- Reset (i_reset=0, async): state IDLE. All outputs 0: strobes, enable, clear, addresses, data, busy. Byte/word counters and shift register cleared. Reset mid-command aborts the command. FIFO contents are not touched.
- RX rule: a byte is consumed only in a cycle where i_rx_empty=0. In that cycle o_rd_uart=1 and i_rx_data is captured. Never pop when empty.
- TX rule: o_wr_uart=1 for exactly one cycle per byte, only when i_tx_full=0. While full, stall in place with data held.
- IDLE: pop one command byte.
  - 'L' (0x4C) -> LD_CNT
  - 'C' (0x43) -> RUN
  - 'S' (0x53) -> STEP
  - 'R' (0x52) -> CLR
  - any other -> send 0x3F ('?') -> IDLE
- LD_CNT: pop count N (0..255 words). Word address resets to 0. If N=0, send 'K' (0x4B) -> IDLE. Otherwise -> LD_BYTE.
- LD_BYTE: pop 4 bytes, little-endian: first byte -> bits [7:0].
- LD_WRITE: one cycle with o_imem_we=1, o_imem_addr=word index, o_imem_wdata=assembled word. Then increment the address (wraps modulo 2^IMEM_ADDR_W) and decrement N. If N reaches 0, send 'K' -> IDLE; else -> LD_BYTE.
- RUN: o_cpu_enable = ~i_halt each cycle. The first cycle with i_halt=1 -> DUMP, with enable 0 in that cycle. If i_halt is already 1 on entry, there are zero enable cycles.
- STEP: o_cpu_enable=1 for exactly one cycle regardless of i_halt -> DUMP.
- CLR: o_cpu_clear=1 for one cycle, send 'K' -> IDLE.
- DUMP: send i_pc (sampled on DUMP entry) as 4 bytes, LSB first. Then for r = 0..NUM_REGS-1:
  - drive o_reg_addr=r and latch i_reg_data into the shift register;
  - send 4 bytes, LSB first.
  - Total 4+4*NUM_REGS bytes (132 at default), then -> IDLE.
  - o_reg_addr returns to 0 in IDLE.
- In RUN, STEP, DUMP and CLR the RX FIFO is never popped; incoming bytes queue.
- o_cpu_enable and o_imem_we are never high in the same cycle.

Test Plan:
- Reset low mid-load, after 2 bytes of a word -> all outputs 0, no o_imem_we. Release reset, then 'L',1,0x78,0x56,0x34,0x12 -> one o_imem_we with addr 0, data 0x12345678, then TX 0x4B.
- 'L',3 + 12 bytes, with i_rx_empty toggling every other cycle -> writes at addrs 0,1,2 with correct words, no pop while empty, one 'K'.
- 'S' with i_pc=0x00000004 and reg r = r*0x01010101 -> exactly 1 enable cycle, then 132 TX bytes starting 04 00 00 00 00 00 00 00 01 01 01 01.
- 'C' with i_halt rising after 10 cycles -> exactly 10 enable cycles, then full dump. 'C' with i_halt=1 already -> 0 enable cycles, then dump.
- i_tx_full held high 50 cycles during dump -> o_wr_uart stays 0, o_tx_data held. After release, the byte stream is complete and in order.
- 'R' -> one-cycle o_cpu_clear, TX 0x4B. Byte 0x7A -> TX 0x3F, FSM back in IDLE, o_busy=0.

Source files
------------

// File: rtl/uart_debug_controller.sv
// UART-driven debug sequencer: loads instruction memory, runs/steps/clears the CPU and
// streams the PC plus the register file back over the UART TX FIFO.
module uart_debug_controller #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned IMEM_ADDR_W = 8,
    parameter int unsigned NUM_REGS    = 32,
    parameter int unsigned REG_ADDR_W  = 5
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_rx_empty,
    input  logic [DATA_W-1:0]      i_rx_data,
    output logic                   o_rd_uart,
    input  logic                   i_tx_full,
    output logic                   o_wr_uart,
    output logic [DATA_W-1:0]      o_tx_data,
    output logic                   o_imem_we,
    output logic [IMEM_ADDR_W-1:0] o_imem_addr,
    output logic [WORD_W-1:0]      o_imem_wdata,
    output logic                   o_cpu_enable,
    output logic                   o_cpu_clear,
    input  logic                   i_halt,
    input  logic [WORD_W-1:0]      i_pc,
    output logic [REG_ADDR_W-1:0]  o_reg_addr,
    input  logic [WORD_W-1:0]      i_reg_data,
    output logic                   o_busy
);

    localparam int unsigned BPW = WORD_W / DATA_W;
    localparam int unsigned BCW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [BCW-1:0]        LAST_BYTE = BCW'(BPW - 1);
    localparam logic [REG_ADDR_W-1:0] LAST_REG  = REG_ADDR_W'(NUM_REGS - 1);

    localparam logic [DATA_W-1:0] CMD_LOAD  = DATA_W'(8'h4C);
    localparam logic [DATA_W-1:0] CMD_RUN   = DATA_W'(8'h43);
    localparam logic [DATA_W-1:0] CMD_STEP  = DATA_W'(8'h53);
    localparam logic [DATA_W-1:0] CMD_CLEAR = DATA_W'(8'h52);
    localparam logic [DATA_W-1:0] RESP_OK   = DATA_W'(8'h4B);
    localparam logic [DATA_W-1:0] RESP_ERR  = DATA_W'(8'h3F);

    typedef enum logic [3:0] {
        StIdle, StLdCnt, StLdByte, StLdWrite, StRun, StStep, StClr, StDumpLoad, StDump, StSend
    } state_e;

    state_e                 state_q, state_d;
    logic [DATA_W-1:0]      cnt_q, cnt_d;
    logic [IMEM_ADDR_W-1:0] addr_q, addr_d;
    logic [BCW-1:0]         byte_q, byte_d;
    logic [WORD_W-1:0]      word_q, word_d;
    logic [WORD_W-1:0]      shift_q, shift_d;
    logic [REG_ADDR_W-1:0]  reg_q, reg_d;
    logic                   dump_pc_q, dump_pc_d;
    logic [DATA_W-1:0]      resp_q, resp_d;
    logic                   rd, wr, we, en, clr;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            addr_q    <= '0;
            byte_q    <= '0;
            word_q    <= '0;
            shift_q   <= '0;
            reg_q     <= '0;
            dump_pc_q <= 1'b0;
            resp_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            byte_q    <= byte_d;
            word_q    <= word_d;
            shift_q   <= shift_d;
            reg_q     <= reg_d;
            dump_pc_q <= dump_pc_d;
            resp_q    <= resp_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        byte_d    = byte_q;
        word_d    = word_q;
        shift_d   = shift_q;
        reg_d     = reg_q;
        dump_pc_d = dump_pc_q;
        resp_d    = resp_q;
        rd        = 1'b0;
        wr        = 1'b0;
        we        = 1'b0;
        en        = 1'b0;
        clr       = 1'b0;
        case (state_q)
            StIdle: begin
                if (!i_rx_empty) begin
                    rd = 1'b1;
                    case (i_rx_data)
                        CMD_LOAD:  state_d = StLdCnt;
                        CMD_RUN:   state_d = StRun;
                        CMD_STEP:  state_d = StStep;
                        CMD_CLEAR: state_d = StClr;
                        default: begin
                            resp_d  = RESP_ERR;
                            state_d = StSend;
                        end
                    endcase
                end
            end
            StLdCnt: begin
                if (!i_rx_empty) begin
                    rd     = 1'b1;
                    cnt_d  = i_rx_data;
                    addr_d = '0;
                    byte_d = '0;
                    if (i_rx_data == '0) begin
                        resp_d  = RESP_OK;
                        state_d = StSend;
                    end else begin
                        state_d = StLdByte;
                    end
                end
            end
            StLdByte: begin
                if (!i_rx_empty) begin
                    rd = 1'b1;
                    word_d[byte_q*DATA_W +: DATA_W] = i_rx_data;
                    if (byte_q == LAST_BYTE) begin
                        byte_d  = '0;
                        state_d = StLdWrite;
                    end else begin
                        byte_d = byte_q + 1'b1;
                    end
                end
            end
            StLdWrite: begin
                we     = 1'b1;
                addr_d = addr_q + 1'b1;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == DATA_W'(1)) begin
                    resp_d  = RESP_OK;
                    state_d = StSend;
                end else begin
                    state_d = StLdByte;
                end
            end
            StRun: begin
                en = ~i_halt;
                if (i_halt) begin
                    dump_pc_d = 1'b1;
                    state_d   = StDumpLoad;
                end
            end
            StStep: begin
                en        = 1'b1;
                dump_pc_d = 1'b1;
                state_d   = StDumpLoad;
            end
            StClr: begin
                clr     = 1'b1;
                resp_d  = RESP_OK;
                state_d = StSend;
            end
            // PC is captured here, one cycle after leaving RUN/STEP, so a step is reflected.
            StDumpLoad: begin
                shift_d = dump_pc_q ? i_pc : i_reg_data;
                byte_d  = '0;
                state_d = StDump;
            end
            StDump: begin
                if (!i_tx_full) begin
                    wr      = 1'b1;
                    shift_d = shift_q >> DATA_W;
                    if (byte_q == LAST_BYTE) begin
                        byte_d = '0;
                        if (dump_pc_q) begin
                            dump_pc_d = 1'b0;
                            state_d   = StDumpLoad;
                        end else if (reg_q == LAST_REG) begin
                            reg_d   = '0;
                            state_d = StIdle;
                        end else begin
                            reg_d   = reg_q + 1'b1;
                            state_d = StDumpLoad;
                        end
                    end else begin
                        byte_d = byte_q + 1'b1;
                    end
                end
            end
            StSend: begin
                if (!i_tx_full) begin
                    wr      = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Pop is gated by reset so a non-empty FIFO is never drained while held in reset.
    assign o_rd_uart    = rd & i_reset;
    assign o_wr_uart    = wr;
    assign o_tx_data    = (state_q == StDump) ? shift_q[DATA_W-1:0] : resp_q;
    assign o_imem_we    = we;
    assign o_imem_addr  = addr_q;
    assign o_imem_wdata = word_q;
    assign o_cpu_enable = en;
    assign o_cpu_clear  = clr;
    assign o_reg_addr   = reg_q;
    assign o_busy       = (state_q != StIdle);

endmodule
